if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFBF_FFFC: PC value loaded by reset; the first fetched address is RESET_PC+4 = 32'hBFC0_0000.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 stall  input  6  pipeline stall vector. Bit 0 = PC/fetch, bit 1 = IF/ID register. 1 = Stop, 0 = NoStop.
REQ-005 br_bus  input  33  {br_e[32], br_addr[31:0]} from decode; redirect request for the next fetch.
REQ-006 if_to_id_bus  output  33  {ce[32], pc[31:0]} to decode.
REQ-007 inst_sram_en  output  1  instruction SRAM enable.
REQ-008 inst_sram_wen  output  4  byte write enables; constant 4'b0000.
REQ-009 inst_sram_addr  output  32  fetch address.
REQ-010 inst_sram_wdata  output  32  constant 32'h0.
REQ-011 inst_sram_rdata  input  32  SRAM read data; valid one cycle after the address is presented.
REQ-012 id_inst  output  32  instruction word presented to decode, stable across decode stalls.

Function
REQ-013 Registers pc_reg (32) and ce_reg (1) SHALL drive the outputs: if_to_id_bus = {ce_reg, pc_reg}, inst_sram_addr = pc_reg, inst_sram_en = ce_reg.
REQ-014 next_pc SHALL be selected by this priority:
- br_e: br_addr;
- pend_v: pend_addr;
- otherwise: pc_reg + 32'h4, 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
REQ-015 When stall[0]=0, at the clock edge: pc_reg <= next_pc; ce_reg <= 1; pend_v <= 0.
REQ-016 When stall[0]=1, pc_reg and ce_reg SHALL hold.
- If br_e=1 in that cycle: pend_v <= 1 and pend_addr <= br_addr (latest request wins).
- Otherwise pend_v and pend_addr hold.
REQ-017 A redirect SHALL never be lost or applied twice. A live br_e in the release cycle overrides the pending address.
REQ-018 The hold buffer SHALL be a two-state FSM with states LIVE and HELD, plus a 32-bit hold_inst register.
REQ-019 In LIVE, id_inst = inst_sram_rdata.
- If stall[1]=1: hold_inst <= inst_sram_rdata, go to HELD.
- Otherwise remain in LIVE.
REQ-020 In HELD, id_inst = hold_inst.
- If stall[1]=1: remain in HELD, hold_inst unchanged.
- If stall[1]=0: go to LIVE. id_inst is still hold_inst during this release cycle.
REQ-021 Latency: decode sees the instruction for a given PC in the cycle after that PC appears on if_to_id_bus. There are zero bubbles when no stall or redirect occurs.
REQ-022 A redirect takes effect on the next unstalled edge. The instruction fetched in the same cycle as the branch (the delay slot) SHALL NOT be squashed.
REQ-023 stall[0]=1 with stall[1]=0 is legal. The FSM follows stall[1] only; the PC follows stall[0] only.
REQ-024 There are no combinational paths from inst_sram_rdata to any output other than id_inst.

Reset
REQ-025 When rst=1 at an edge, all registers SHALL take these values, regardless of stall and br_bus:
- pc_reg = RESET_PC;
- ce_reg = 0;
- pend_v = 0, pend_addr = 0;
- FSM = LIVE;
- hold_inst = 0.
REQ-026 During and after reset until the first unstalled edge, the outputs SHALL be:
- inst_sram_en = 0;
- if_to_id_bus = {1'b0, 32'hBFBF_FFFC};
- id_inst = inst_sram_rdata.
REQ-027 Reset asserted while in HELD or with a pending redirect SHALL discard both. The first fetch after reset is 32'hBFC0_0000.

Verification
REQ-028 Release rst with stall=0 for 4 cycles -> inst_sram_addr = BFC00000, BFC00004, BFC00008, BFC0000C; ce=1 from the first post-reset edge.
REQ-029 br_e=1, br_addr=32'h8000_0100, pulsed one cycle while pc_reg=BFC00008 -> next pc_reg=80000100, then 80000104.
REQ-030 stall=6'b000011 for 3 cycles while rdata=32'h3C01_1234; rdata changes to 32'h2421_0004 during the stall -> id_inst = 3C011234 for every stalled cycle and the release cycle, then follows rdata.
REQ-031 br_e=1, br_addr=32'h8000_0200, pulsed during stall[0]=1, then stall removed 2 cycles later -> pc_reg=80000200 after the release edge; a second release does not re-apply it.
REQ-032 Pending redirect to 80000200 plus a live br_e with br_addr=80000300 in the release cycle -> pc_reg=80000300.
REQ-033 rst asserted mid-stall while in HELD with pend_v=1 -> after reset: LIVE, pend_v=0, pc_reg=BFBFFFFC, then first fetch at BFC00000.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: PC generation with stall-safe redirect buffering and a decode-side instruction hold buffer.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] id_inst
);
    typedef enum logic {LIVE, HELD} hold_state_t;
    hold_state_t r_state;
    logic [31:0] r_pc, r_pend_addr, r_hold_inst;
    logic        r_ce, r_pend_v;
    logic        w_br_e, w_unused;
    logic [31:0] w_br_addr, w_next_pc;
    assign {w_br_e, w_br_addr} = br_bus;
    assign w_unused = ^stall[5:2];
    // A live redirect beats a buffered one; the buffer only exists to survive fetch stalls.
    assign w_next_pc = w_br_e ? w_br_addr : r_pend_v ? r_pend_addr : r_pc + 32'h4;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_ce        <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
            r_state     <= LIVE;
            r_hold_inst <= '0;
        end else begin
            if (!stall[0]) begin
                r_pc     <= w_next_pc;
                r_ce     <= 1'b1;
                r_pend_v <= 1'b0;
            end else if (w_br_e) begin
                r_pend_v    <= 1'b1;
                r_pend_addr <= w_br_addr;
            end
            if (r_state == LIVE && stall[1]) r_hold_inst <= inst_sram_rdata;
            r_state <= stall[1] ? HELD : LIVE;
        end
    end
    assign if_to_id_bus    = {r_ce, r_pc};
    assign inst_sram_en    = r_ce;
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0;
    assign id_inst         = (r_state == HELD) ? r_hold_inst : inst_sram_rdata;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vector table for the fetch corner cases, then random traffic against a reference model.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [31:0] rdata;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_wdata, id_inst;
    int checks = 0, errors = 0;

    if_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
        .if_to_id_bus(if_to_id_bus), .inst_sram_en(inst_sram_en),
        .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(rdata), .id_inst(id_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic [32:0] br;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic        e_en;
        logic [31:0] e_inst;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic [5:0] s, input logic [32:0] b,
                               input logic [31:0] d, input logic [31:0] a, input logic e, input logic [31:0] ins);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.rdata = d; x.e_addr = a; x.e_en = e; x.e_inst = ins;
        return x;
    endfunction

    // Reference model: fetch address, valid flag, and the newest redirect not yet consumed.
    // Decode sees a held word whenever the previous cycle stalled IF/ID; the held word is the
    // one that was live when that stall run began.
    logic [31:0] m_pc, m_redir, m_run_word;
    logic        m_ce, m_has_redir, m_prev_stall1, m_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] s, input logic [32:0] b, input logic [31:0] d);
        rst = r; stall = s; br_bus = b; rdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_pc = 32'hBFBF_FFFC; m_ce = 1'b0; m_has_redir = 1'b0; m_redir = '0;
            m_prev_stall1 = 1'b0; m_run_word = '0; m_valid = 1'b1;
        end else begin
            if (!stall[0]) begin
                m_pc = br_bus[32] ? br_bus[31:0] : m_has_redir ? m_redir : m_pc + 32'd4;
                m_ce = 1'b1;
                m_has_redir = 1'b0;
            end else if (br_bus[32]) begin
                m_has_redir = 1'b1;
                m_redir = br_bus[31:0];
            end
            if (stall[1] && !m_prev_stall1) m_run_word = rdata;
            m_prev_stall1 = stall[1];
        end
        #1;
    endtask

    localparam logic [32:0] NB = 33'h0;

    initial begin
        tbl.push_back(v(1, 6'h3F, {1'b1, 32'h8000_0000}, 32'h1111_1111, 32'hBFBF_FFFC, 0, 32'h1111_1111));
        tbl.push_back(v(0, 6'h00, NB, 32'hA000_0000, 32'hBFBF_FFFC, 0, 32'hA000_0000));
        tbl.push_back(v(0, 6'h00, NB, 32'hA000_0001, 32'hBFC0_0000, 1, 32'hA000_0001));
        tbl.push_back(v(0, 6'h00, NB, 32'hA000_0002, 32'hBFC0_0004, 1, 32'hA000_0002));
        tbl.push_back(v(0, 6'h00, NB, 32'hA000_0003, 32'hBFC0_0008, 1, 32'hA000_0003));
        tbl.push_back(v(0, 6'h00, NB, 32'hA000_0004, 32'hBFC0_000C, 1, 32'hA000_0004));
        tbl.push_back(v(1, 6'h00, NB, 32'hA000_0005, 32'hBFC0_0010, 1, 32'hA000_0005));
        tbl.push_back(v(0, 6'h00, NB, 32'hA000_0006, 32'hBFBF_FFFC, 0, 32'hA000_0006));
        tbl.push_back(v(0, 6'h00, NB, 32'hA000_0007, 32'hBFC0_0000, 1, 32'hA000_0007));
        tbl.push_back(v(0, 6'h00, NB, 32'hA000_0008, 32'hBFC0_0004, 1, 32'hA000_0008));
        tbl.push_back(v(0, 6'h00, {1'b1, 32'h8000_0100}, 32'hA000_0009, 32'hBFC0_0008, 1, 32'hA000_0009));
        tbl.push_back(v(0, 6'h00, NB, 32'hA000_000A, 32'h8000_0100, 1, 32'hA000_000A));
        tbl.push_back(v(0, 6'h03, NB, 32'h3C01_1234, 32'h8000_0104, 1, 32'h3C01_1234));
        tbl.push_back(v(0, 6'h03, NB, 32'h2421_0004, 32'h8000_0104, 1, 32'h3C01_1234));
        tbl.push_back(v(0, 6'h03, NB, 32'h2421_0004, 32'h8000_0104, 1, 32'h3C01_1234));
        tbl.push_back(v(0, 6'h00, NB, 32'h2421_0004, 32'h8000_0104, 1, 32'h3C01_1234));
        tbl.push_back(v(0, 6'h00, NB, 32'h2421_0004, 32'h8000_0108, 1, 32'h2421_0004));
        tbl.push_back(v(0, 6'h01, {1'b1, 32'h8000_0200}, 32'hC000_0000, 32'h8000_010C, 1, 32'hC000_0000));
        tbl.push_back(v(0, 6'h01, NB, 32'hC000_0001, 32'h8000_010C, 1, 32'hC000_0001));
        tbl.push_back(v(0, 6'h00, NB, 32'hC000_0002, 32'h8000_010C, 1, 32'hC000_0002));
        tbl.push_back(v(0, 6'h00, NB, 32'hC000_0003, 32'h8000_0200, 1, 32'hC000_0003));
        tbl.push_back(v(0, 6'h00, NB, 32'hC000_0004, 32'h8000_0204, 1, 32'hC000_0004));
        tbl.push_back(v(0, 6'h01, {1'b1, 32'h8000_0200}, 32'hC000_0005, 32'h8000_0208, 1, 32'hC000_0005));
        tbl.push_back(v(0, 6'h00, {1'b1, 32'h8000_0300}, 32'hC000_0006, 32'h8000_0208, 1, 32'hC000_0006));
        tbl.push_back(v(0, 6'h00, NB, 32'hC000_0007, 32'h8000_0300, 1, 32'hC000_0007));
        tbl.push_back(v(0, 6'h03, {1'b1, 32'h8000_0400}, 32'hD000_0000, 32'h8000_0304, 1, 32'hD000_0000));
        tbl.push_back(v(0, 6'h03, NB, 32'hD000_0001, 32'h8000_0304, 1, 32'hD000_0000));
        tbl.push_back(v(1, 6'h03, NB, 32'hD000_0002, 32'h8000_0304, 1, 32'hD000_0000));
        tbl.push_back(v(0, 6'h00, NB, 32'hD000_0003, 32'hBFBF_FFFC, 0, 32'hD000_0003));
        tbl.push_back(v(0, 6'h00, NB, 32'hD000_0004, 32'hBFC0_0000, 1, 32'hD000_0004));

        drive(1, 6'h00, NB, 32'h0);
        tick();
        tick();
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].rdata);
            #4;
            chk($sformatf("vec%0d addr", i), 64'(inst_sram_addr), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d en", i), 64'(inst_sram_en), 64'(tbl[i].e_en));
            chk($sformatf("vec%0d bus", i), 64'(if_to_id_bus), 64'({tbl[i].e_en, tbl[i].e_addr}));
            chk($sformatf("vec%0d inst", i), 64'(id_inst), 64'(tbl[i].e_inst));
            tick();
        end

        for (int i = 0; i < 800; i++) begin
            logic [31:0] ba;
            ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive(i < 2 || $urandom_range(0, 59) == 0,
                  6'($urandom) & 6'($urandom),
                  {$urandom_range(0, 4) == 0, ba},
                  $urandom);
            #4;
            if (m_valid) begin
                chk($sformatf("rnd%0d bus", i), 64'(if_to_id_bus), 64'({m_ce, m_pc}));
                chk($sformatf("rnd%0d addr", i), 64'(inst_sram_addr), 64'(m_pc));
                chk($sformatf("rnd%0d en", i), 64'(inst_sram_en), 64'(m_ce));
                chk($sformatf("rnd%0d wen", i), 64'(inst_sram_wen), 64'h0);
                chk($sformatf("rnd%0d wdata", i), 64'(inst_sram_wdata), 64'h0);
                chk($sformatf("rnd%0d inst", i), 64'(id_inst), 64'(m_prev_stall1 ? m_run_word : rdata));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
